// File: rtl/cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and helpers for the cache-miss stall controller.
//   i_state_e  : I-side miss FSM states (idle / waiting on refill / dropping
//                a wrong-path refill after a redirect).
//   range_mask : builds a vector with bits lo..hi set, clipped to 'width'.
//                Out-of-range bits (e.g. a bubble slot past the last stage)
//                simply vanish, which keeps the top-level constants uniform.
// -----------------------------------------------------------------------------
package cache_ctrl_pkg;

    localparam int MASK_W = 64;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_WAIT = 2'd1,
        I_DROP = 2'd2
    } i_state_e;

    function automatic logic [MASK_W-1:0] range_mask(input int lo, input int hi, input int width);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < width && i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cache_miss_fsm.sv
// -----------------------------------------------------------------------------
// cache_miss_fsm
// I-cache miss tracker. Remembers that an outstanding fetch has become
// wrong-path because of a redirect, so its late response can be discarded.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_valid    : I-cache request outstanding
//   i_ready    : I-cache response returned
//   redirect   : redirect being applied this cycle
//   state      : current FSM state (registered)
//   drop_exit  : combinational, high on the cycle a wrong-path refill returns
// -----------------------------------------------------------------------------
module cache_miss_fsm
    import cache_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_valid,
    input  logic     i_ready,
    input  logic     redirect,
    output i_state_e state,
    output logic     drop_exit
);

    i_state_e state_nxt;
    logic     i_miss;

    assign i_miss = i_valid & ~i_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= I_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        drop_exit = 1'b0;
        case (state)
            I_IDLE: if (i_miss) state_nxt = I_WAIT;
            I_WAIT: begin
                if (i_ready)                 state_nxt = I_IDLE;
                else if (redirect && i_miss) state_nxt = I_DROP;
            end
            I_DROP: begin
                // A further redirect while dropping changes nothing.
                if (i_ready) begin
                    state_nxt = I_IDLE;
                    drop_exit = 1'b1;
                end
            end
            default: state_nxt = I_IDLE;
        endcase
    end

endmodule

// File: rtl/cache_stall_ctrl.sv
// -----------------------------------------------------------------------------
// cache_stall_ctrl
// Pipeline hazard controller for I- and D-cache miss stalls. Produces
// registered per-stage stall and flush (bubble) vectors; index 0 is the PC,
// index k is the k-th pipeline register.
// Optional build macro: CACHE_PERF_CNT_EN adds saturating miss-cycle counters;
// without it the counter ports are constant 0.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_valid/i_ready  : I-cache request outstanding / response returned
//   d_valid/d_ready  : D-cache request outstanding / response returned
//   redirect         : one-cycle branch/exception redirect pulse from EX
//   stall_vec        : registered stall per pipeline register
//   flush_vec        : registered flush per pipeline register
//   i_busy           : I-FSM not idle
//   d_busy           : D-side miss in progress (registered)
//   i_miss_cycles    : I-miss cycle count (perf build only)
//   d_miss_cycles    : D-miss cycle count (perf build only)
// -----------------------------------------------------------------------------
module cache_stall_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 6,
    parameter int IF_IDX     = 1,
    parameter int MEM_IDX    = 4,
    parameter int RED_IDX    = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_ready,
    input  logic                  d_valid,
    input  logic                  d_ready,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stall_vec,
    output logic [NUM_STAGES-1:0] flush_vec,
    output logic                  i_busy,
    output logic                  d_busy,
    output logic [CNT_W-1:0]      i_miss_cycles,
    output logic [CNT_W-1:0]      d_miss_cycles
);

    localparam logic [MASK_W-1:0] I_STALL_W = range_mask(0, IF_IDX, NUM_STAGES);
    localparam logic [MASK_W-1:0] I_FLUSH_W = range_mask(IF_IDX + 1, IF_IDX + 1, NUM_STAGES);
    localparam logic [MASK_W-1:0] D_STALL_W = range_mask(0, MEM_IDX, NUM_STAGES);
    // Drops out automatically when MEM_IDX is the last stage.
    localparam logic [MASK_W-1:0] D_FLUSH_W = range_mask(MEM_IDX + 1, MEM_IDX + 1, NUM_STAGES);
    localparam logic [MASK_W-1:0] RED_W     = range_mask(1, RED_IDX, NUM_STAGES);

    localparam logic [NUM_STAGES-1:0] I_STALL = I_STALL_W[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] I_FLUSH = I_FLUSH_W[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] D_STALL = D_STALL_W[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] D_FLUSH = D_FLUSH_W[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] RED_M   = RED_W[NUM_STAGES-1:0];

    logic                  i_miss, d_miss;
    logic                  red_pend, red_now;
    logic                  drop_exit;
    i_state_e              i_state;
    logic [NUM_STAGES-1:0] stall_nxt, flush_nxt;

    assign i_miss = i_valid & ~i_ready;
    assign d_miss = d_valid & ~d_ready;

    // A redirect cannot flush stages that a D-miss is holding, so it is
    // parked in red_pend and released on the first cycle without a D-miss.
    assign red_now = (redirect | red_pend) & ~d_miss;

    cache_miss_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .redirect  (red_now),
        .state     (i_state),
        .drop_exit (drop_exit)
    );

    assign i_busy = (i_state != I_IDLE);

    always_comb begin
        stall_nxt = '0;
        flush_nxt = '0;
        if (i_miss) begin
            stall_nxt = stall_nxt | I_STALL;
            flush_nxt = flush_nxt | I_FLUSH;
        end
        // Wrong-path refill has landed: bubble it out of IF.
        if (drop_exit) flush_nxt = flush_nxt | I_FLUSH;
        if (d_miss) begin
            stall_nxt = stall_nxt | D_STALL;
            flush_nxt = flush_nxt | D_FLUSH;
        end
        // PC stall (bit 0) is kept; the PC module loads the target itself.
        if (red_now) begin
            stall_nxt = stall_nxt & ~RED_M;
            flush_nxt = flush_nxt | RED_M;
        end
        // A stalled stage holds its contents, so it can never also be
        // bubbled; this is what lets a D-miss override the I-side bubble.
        flush_nxt = flush_nxt & ~stall_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_vec <= '0;
            flush_vec <= '0;
            d_busy    <= 1'b0;
            red_pend  <= 1'b0;
        end else begin
            stall_vec <= stall_nxt;
            flush_vec <= flush_nxt;
            d_busy    <= d_miss;
            red_pend  <= (redirect | red_pend) & d_miss;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] i_cnt, d_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (i_miss && i_cnt != '1) i_cnt <= i_cnt + 1'b1;
            if (d_miss && d_cnt != '1) d_cnt <= d_cnt + 1'b1;
        end
    end

    assign i_miss_cycles = i_cnt;
    assign d_miss_cycles = d_cnt;
`else
    assign i_miss_cycles = '0;
    assign d_miss_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_stall_ctrl
// Directed bench for cache_stall_ctrl with NUM_STAGES=6, IF_IDX=1, MEM_IDX=4,
// RED_IDX=3. Inputs change 1 ns after a rising edge; outputs are read 1 ns
// after the following edge, i.e. they reflect the previous cycle's inputs.
// -----------------------------------------------------------------------------
module tb_cache_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, d_valid, d_ready, redirect;
    logic [5:0]  stall_vec, flush_vec;
    logic        i_busy, d_busy;
    logic [31:0] i_miss_cycles, d_miss_cycles;

    int vectors = 0;
    int errors  = 0;

`ifdef CACHE_PERF_CNT_EN
    localparam logic [31:0] EXP_I_CNT = 32'd3;
`else
    localparam logic [31:0] EXP_I_CNT = 32'd0;
`endif

    cache_stall_ctrl #(
        .NUM_STAGES (6),
        .IF_IDX     (1),
        .MEM_IDX    (4),
        .RED_IDX    (3),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .d_valid       (d_valid),
        .d_ready       (d_ready),
        .redirect      (redirect),
        .stall_vec     (stall_vec),
        .flush_vec     (flush_vec),
        .i_busy        (i_busy),
        .d_busy        (d_busy),
        .i_miss_cycles (i_miss_cycles),
        .d_miss_cycles (d_miss_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        d_valid  = 1'b0;
        d_ready  = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || i_busy !== 1'b0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b flush=%b i_busy=%b d_busy=%b, want all zero",
                     stall_vec, flush_vec, i_busy, d_busy);
        end
        vectors++;
        if (i_miss_cycles !== 32'd0 || d_miss_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: i=%0d d=%0d, want 0 0", i_miss_cycles, d_miss_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_i_miss();
        i_valid = 1'b1;
        i_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (stall_vec !== 6'b000011 || flush_vec !== 6'b000100 || i_busy !== 1'b1) begin
                errors++;
                $display("FAIL i_miss_cycle%0d: stall=%b flush=%b busy=%b, want 000011 000100 1",
                         c, stall_vec, flush_vec, i_busy);
            end
        end
        i_ready = 1'b1;
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || i_busy !== 1'b0) begin
            errors++;
            $display("FAIL i_miss_done: stall=%b flush=%b busy=%b, want 000000 000000 0",
                     stall_vec, flush_vec, i_busy);
        end
        idle_inputs();
        tick();
        vectors++;
        if (i_miss_cycles !== EXP_I_CNT || d_miss_cycles !== 32'd0) begin
            errors++;
            $display("FAIL i_miss_count: i=%0d d=%0d, want %0d 0", i_miss_cycles, d_miss_cycles, EXP_I_CNT);
        end
    endtask

    task automatic test_d_miss();
        d_valid = 1'b1;
        d_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (stall_vec !== 6'b011111 || flush_vec !== 6'b100000 || d_busy !== 1'b1) begin
                errors++;
                $display("FAIL d_miss_cycle%0d: stall=%b flush=%b d_busy=%b, want 011111 100000 1",
                         c, stall_vec, flush_vec, d_busy);
            end
        end
        d_ready = 1'b1;
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL d_miss_done: stall=%b flush=%b d_busy=%b, want 000000 000000 0",
                     stall_vec, flush_vec, d_busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_both_miss();
        i_valid = 1'b1;
        i_ready = 1'b0;
        d_valid = 1'b1;
        d_ready = 1'b0;
        tick();
        vectors++;
        if (stall_vec !== 6'b011111 || flush_vec !== 6'b100000) begin
            errors++;
            $display("FAIL both_miss: stall=%b flush=%b, want 011111 100000", stall_vec, flush_vec);
        end
        i_ready = 1'b1;
        d_ready = 1'b1;
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || i_busy !== 1'b0) begin
            errors++;
            $display("FAIL both_miss_done: stall=%b flush=%b busy=%b, want 000000 000000 0",
                     stall_vec, flush_vec, i_busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_redirect_idle();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b001110) begin
            errors++;
            $display("FAIL redirect_idle: stall=%b flush=%b, want 000000 001110", stall_vec, flush_vec);
        end
        tick();
        vectors++;
        if (flush_vec !== 6'b0) begin
            errors++;
            $display("FAIL redirect_idle_clear: flush=%b, want 000000", flush_vec);
        end
    endtask

    task automatic test_redirect_i_miss();
        i_valid = 1'b1;
        i_ready = 1'b0;
        tick();                      // miss already in I_WAIT
        redirect = 1'b1;             // cycle N
        tick();
        redirect = 1'b0;
        vectors++;
        if (stall_vec !== 6'b000001 || flush_vec !== 6'b001110) begin
            errors++;
            $display("FAIL red_i_n1: stall=%b flush=%b, want 000001 001110", stall_vec, flush_vec);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            vectors++;
            if (stall_vec !== 6'b000011 || flush_vec !== 6'b000100 || i_busy !== 1'b1) begin
                errors++;
                $display("FAIL red_i_n%0d: stall=%b flush=%b busy=%b, want 000011 000100 1",
                         c, stall_vec, flush_vec, i_busy);
            end
        end
        i_ready = 1'b1;              // cycle N+3
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b000100 || i_busy !== 1'b0) begin
            errors++;
            $display("FAIL red_i_drop_exit: stall=%b flush=%b busy=%b, want 000000 000100 0",
                     stall_vec, flush_vec, i_busy);
        end
        idle_inputs();
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0) begin
            errors++;
            $display("FAIL red_i_after: stall=%b flush=%b, want 000000 000000", stall_vec, flush_vec);
        end
    endtask

    task automatic test_redirect_d_miss();
        d_valid = 1'b1;
        d_ready = 1'b0;
        tick();
        redirect = 1'b1;             // cycle N
        tick();
        redirect = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) tick();
            vectors++;
            if (stall_vec !== 6'b011111 || flush_vec !== 6'b100000) begin
                errors++;
                $display("FAIL red_d_held%0d: stall=%b flush=%b, want 011111 100000",
                         c, stall_vec, flush_vec);
            end
        end
        d_ready = 1'b1;              // cycle N+2: d_miss drops
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b001110) begin
            errors++;
            $display("FAIL red_d_release: stall=%b flush=%b, want 000000 001110", stall_vec, flush_vec);
        end
        idle_inputs();
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0) begin
            errors++;
            $display("FAIL red_d_cleared: stall=%b flush=%b, want 000000 000000", stall_vec, flush_vec);
        end
    endtask

    task automatic test_reset_mid_drop();
        i_valid = 1'b1;
        i_ready = 1'b0;
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        vectors++;
        if (i_busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy: busy=%b, want 1", i_busy);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || i_busy !== 1'b0 || d_busy !== 1'b0 ||
            i_miss_cycles !== 32'd0 || d_miss_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_drop: stall=%b flush=%b busy=%b/%b cnt=%0d/%0d, want all zero",
                     stall_vec, flush_vec, i_busy, d_busy, i_miss_cycles, d_miss_cycles);
        end
        rst = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        vectors++;
        if (stall_vec !== 6'b0 || flush_vec !== 6'b0 || i_busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_after_reset: stall=%b flush=%b busy=%b, want 000000 000000 0",
                     stall_vec, flush_vec, i_busy);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_i_miss();
        test_d_miss();
        test_both_miss();
        test_redirect_idle();
        test_redirect_i_miss();
        test_redirect_d_miss();
        test_reset_mid_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
